tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_word_decode.sv | 43 ++++
 rtl/tmds_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared constants and types for the TMDS decoder:
//   - the four 10-bit control tokens and their {c1,c0} values
//   - SLIP_HOLD: cycles the aligner waits after a bitslip request so the
//     deserializer has time to apply the shift before the search resumes
//   - align_state_t: word-alignment FSM states
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    localparam int SLIP_HOLD = 3;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } align_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// -----------------------------------------------------------------------------
// tmds_word_decode
// Purely combinational decode of one 10-bit TMDS word.
//   i_tmds    : 10-bit TMDS word
//   o_is_ctrl : 1 when i_tmds is one of the four control tokens
//   o_ctrl    : {c1,c0} of the matched token (0 when not a token)
//   o_data    : decoded pixel byte (meaningful only when o_is_ctrl = 0)
// Bit 9 of the word flags inversion of the low byte; bit 8 selects whether
// neighbouring bits were chained with XOR (1) or XNOR (0).
// -----------------------------------------------------------------------------
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_tmds,
    output logic       o_is_ctrl,
    output logic [1:0] o_ctrl,
    output logic [7:0] o_data
);

    logic [7:0] w_q;

    always_comb begin
        o_is_ctrl = 1'b1;
        o_ctrl    = 2'b00;
        case (i_tmds)
            TOK_C00: o_ctrl = 2'b00;
            TOK_C01: o_ctrl = 2'b01;
            TOK_C10: o_ctrl = 2'b10;
            TOK_C11: o_ctrl = 2'b11;
            default: o_is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        w_q       = i_tmds[9] ? ~i_tmds[7:0] : i_tmds[7:0];
        o_data    = 8'h00;
        o_data[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            o_data[i] = i_tmds[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
// TMDS channel decoder with control-token based word alignment.
//
// Parameters
//   WINDOW   : cycles allowed without a completed control run before a
//              bitslip request (SEARCH) or loss of lock (LOCKED)
//   CTRL_RUN : consecutive control tokens that form a completed run
//
// Ports
//   clk_in        : pixel clock, all logic on the rising edge
//   rst_in        : synchronous active-high reset
//   tmds_in       : deserialized 10-bit TMDS word, one per cycle
//   data_out      : decoded byte (0 for control words), 2-cycle latency
//   control_out   : last decoded control value {c1,c0}, held across data
//   de_out        : 1 when the output word is a data word
//   locked_out    : word alignment acquired
//   bitslip_out   : one-cycle request for a 1-bit deserializer word shift
//   err_count_out : alignment error count (bitslips + lock losses)
//   state_out     : alignment FSM state, for observation only
//
// Build option
//   TMDS_DECODER_ERRCNT_EN : when defined, err_count_out is a saturating
//   counter of alignment errors; otherwise it is constant 0.
//
// Decoding runs in every alignment state; lock status never gates outputs.
// -----------------------------------------------------------------------------
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int WINDOW   = 2048,
    parameter int CTRL_RUN = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  tmds_in,
    output logic [7:0]  data_out,
    output logic [1:0]  control_out,
    output logic        de_out,
    output logic        locked_out,
    output logic        bitslip_out,
    output logic [15:0] err_count_out,
    output logic [1:0]  state_out
);

    localparam int WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int HOLD_W = $clog2(SLIP_HOLD + 1);

    // ---------------- combinational word decode ----------------
    logic       w_is_ctrl;
    logic [1:0] w_ctrl;
    logic [7:0] w_data;

    tmds_word_decode u_word_decode (
        .i_tmds    (tmds_in),
        .o_is_ctrl (w_is_ctrl),
        .o_ctrl    (w_ctrl),
        .o_data    (w_data)
    );

    // ---------------- decode pipeline (2 stages) ----------------
    // r_s1_vld keeps the reset value on the outputs until a real word has
    // passed through stage 1, so the first word after reset appears exactly
    // two cycles after rst_in falls.
    logic       r_s1_vld;
    logic       r_s1_is_ctrl;
    logic [1:0] r_s1_ctrl;
    logic [7:0] r_s1_data;
    logic [7:0] r_data;
    logic [1:0] r_ctrl;
    logic       r_de;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_vld     <= 1'b0;
            r_s1_is_ctrl <= 1'b0;
            r_s1_ctrl    <= 2'b00;
            r_s1_data    <= 8'h00;
        end else begin
            r_s1_vld     <= 1'b1;
            r_s1_is_ctrl <= w_is_ctrl;
            r_s1_ctrl    <= w_ctrl;
            r_s1_data    <= w_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_data <= 8'h00;
            r_ctrl <= 2'b00;
            r_de   <= 1'b0;
        end else if (r_s1_vld) begin
            r_de   <= ~r_s1_is_ctrl;
            r_data <= r_s1_is_ctrl ? 8'h00 : r_s1_data;
            if (r_s1_is_ctrl) begin
                r_ctrl <= r_s1_ctrl;
            end
        end
    end

    assign data_out    = r_data;
    assign control_out = r_ctrl;
    assign de_out      = r_de;

    // ---------------- alignment FSM ----------------
    align_state_t      r_state;
    align_state_t      w_state_next;
    logic [RUN_W-1:0]  r_run;
    logic [WIN_W-1:0]  r_win;
    logic [HOLD_W-1:0] r_hold;

    logic w_run_hit;
    logic w_win_exp;
    logic w_hold_done;
    logic w_win_clr;
    logic w_win_inc;
    logic w_bitslip;
    logic w_lock_lost;

    assign w_run_hit   = (r_run == RUN_W'(CTRL_RUN));
    assign w_win_exp   = (r_win == WIN_W'(WINDOW - 1));
    assign w_hold_done = (r_hold == HOLD_W'(SLIP_HOLD - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completed run takes priority over window expiry, so a run finishing
    // on the expiry cycle locks instead of slipping.
    always_comb begin
        w_state_next = r_state;
        w_win_clr    = 1'b0;
        w_win_inc    = 1'b0;
        w_bitslip    = 1'b0;
        w_lock_lost  = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_run_hit) begin
                    w_state_next = ST_LOCKED;
                    w_win_clr    = 1'b1;
                end else if (w_win_exp) begin
                    w_state_next = ST_SLIP_WAIT;
                    w_win_clr    = 1'b1;
                    w_bitslip    = 1'b1;
                end else begin
                    w_win_inc    = 1'b1;
                end
            end
            ST_SLIP_WAIT: begin
                w_win_clr = 1'b1;
                if (w_hold_done) begin
                    w_state_next = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (w_run_hit) begin
                    w_win_clr    = 1'b1;
                end else if (w_win_exp) begin
                    w_state_next = ST_SEARCH;
                    w_win_clr    = 1'b1;
                    w_lock_lost  = 1'b1;
                end else begin
                    w_win_inc    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_win_clr    = 1'b1;
            end
        endcase
    end

    // Run counter: consecutive control tokens, saturating. Held at zero while
    // waiting for the deserializer to apply a slip, since words in flight
    // still carry the old alignment.
    always_ff @(posedge clk_in) begin
        if (rst_in || (r_state == ST_SLIP_WAIT)) begin
            r_run <= '0;
        end else if (w_is_ctrl) begin
            if (!w_run_hit) begin
                r_run <= r_run + RUN_W'(1);
            end
        end else begin
            r_run <= '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || w_win_clr) begin
            r_win <= '0;
        end else if (w_win_inc) begin
            r_win <= r_win + WIN_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (r_state != ST_SLIP_WAIT)) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

    assign locked_out  = (r_state == ST_LOCKED);
    assign bitslip_out = w_bitslip;
    assign state_out   = r_state;

    // ---------------- alignment error counter ----------------
`ifdef TMDS_DECODER_ERRCNT_EN
    logic [15:0] r_err;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_err <= 16'h0000;
        end else if ((w_bitslip || w_lock_lost) && (r_err != 16'hFFFF)) begin
            r_err <= r_err + 16'h0001;
        end
    end

    assign err_count_out = r_err;
`else
    logic w_unused_err;
    assign w_unused_err  = w_lock_lost;
    assign err_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
// Directed + randomized bench for tmds_decoder (WINDOW=64, CTRL_RUN=8).
// Cycle numbering: cycle 0 is the period right after the last reset edge.
// Inputs are driven and outputs sampled on the falling clock edge; a word
// driven in cycle c is expected on the outputs in cycle c+2.
// -----------------------------------------------------------------------------
module tb_tmds_decoder;
    import tmds_pkg::*;

    localparam int WIN = 64;
    localparam int RUN = 8;
`ifdef TMDS_DECODER_ERRCNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [9:0]  tmds_in = 10'd0;
    logic [7:0]  data_out;
    logic [1:0]  control_out;
    logic        de_out;
    logic        locked_out;
    logic        bitslip_out;
    logic [15:0] err_count_out;
    logic [1:0]  state_out;

    always #5 clk_in = ~clk_in;

    tmds_decoder #(.WINDOW(WIN), .CTRL_RUN(RUN)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .tmds_in       (tmds_in),
        .data_out      (data_out),
        .control_out   (control_out),
        .de_out        (de_out),
        .locked_out    (locked_out),
        .bitslip_out   (bitslip_out),
        .err_count_out (err_count_out),
        .state_out     (state_out)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [9:0]  tok [4] = '{10'b1101010100, 10'b0010101011,
                             10'b0101010100, 10'b1010101011};
    logic [10:0] exp_q [$];   // {de, control, data}
    logic [1:0]  m_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, slip_cnt, slip_cyc, rise_cyc, fall_cyc;
    logic prev_locked;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        int k;
        k = -1;
        for (int i = 0; i < 4; i++) if (w == tok[i]) k = i;
        return k;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_index(w) >= 0);
        return w;
    endfunction

    task automatic model_push(input logic [9:0] w);
        logic [7:0] q, d;
        int k;
        k = tok_index(w);
        if (k >= 0) begin
            m_ctrl = 2'(k);
            exp_q.push_back({1'b0, m_ctrl, 8'h00});
        end else begin
            q    = w[9] ? ~w[7:0] : w[7:0];
            d[0] = q[0];
            for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
            exp_q.push_back({1'b1, m_ctrl, d});
        end
    endtask

    // ---------------- driver ----------------
    // Observe the current cycle, then drive the word for this cycle.
    task automatic tick(input logic [9:0] w);
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("decode", 16'({de_out, control_out, data_out}), 16'(e));
        if (bitslip_out === 1'b1) begin
            slip_cnt++;
            slip_cyc = cyc;
        end
        if (locked_out === 1'b1 && !prev_locked) rise_cyc = cyc;
        if (locked_out !== 1'b1 && prev_locked) fall_cyc = cyc;
        prev_locked = (locked_out === 1'b1);
        tmds_in = w;
        model_push(w);
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic do_reset(input int edges);
        rst_in  = 1'b1;
        tmds_in = 10'd0;
        repeat (edges) @(negedge clk_in);
        rst_in = 1'b0;
        cyc    = 0;
        exp_q.delete();
        exp_q.push_back(11'd0);
        exp_q.push_back(11'd0);
        m_ctrl      = 2'b00;
        slip_cnt    = 0;
        slip_cyc    = -1;
        rise_cyc    = -1;
        fall_cyc    = -1;
        prev_locked = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_data"},    16'(data_out),    16'd0);
        chk({tag, "_ctrl"},    16'(control_out), 16'd0);
        chk({tag, "_de"},      16'(de_out),      16'd0);
        chk({tag, "_locked"},  16'(locked_out),  16'd0);
        chk({tag, "_bitslip"}, 16'(bitslip_out), 16'd0);
        chk({tag, "_err"},     err_count_out,    16'd0);
        chk({tag, "_state"},   16'(state_out),   16'(ST_SEARCH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [9:0] rot;
        logic [9:0] t0;
        int d, n, m;

        t0  = tok[0];
        rot = {t0[2:0], t0[9:3]};

        do_reset(3);
        check_reset("por");

        // Control run from reset: 8 tokens in cycles 0..7 -> locked from cycle 9.
        repeat (12) tick(tok[0]);
        chk("lock_cycle", 16'(rise_cyc), 16'd9);
        chk("no_slip_initial", 16'(slip_cnt), 16'd0);

        // Directed data words while locked.
        tick(10'b0100000000);
        tick(10'b1011111111);
        chk("locked_during_data", 16'(locked_out), 16'd1);

        // Random token bursts and data bursts, short enough to keep lock.
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(RUN, RUN + 4);
            m = $urandom_range(1, 40);
            repeat (n) tick(tok[$urandom_range(0, 3)]);
            repeat (m) tick(rand_data());
        end
        chk("no_unlock_random", 16'(fall_cyc), 16'hFFFF);
        chk("no_slip_random", 16'(slip_cnt), 16'd0);

        // Lock loss: data-only stream for more than a window.
        repeat (10) tick(tok[$urandom_range(0, 3)]);
        d = cyc;
        repeat (WIN + 8) tick(rand_data());
        chk("unlock_cycle", 16'(fall_cyc), 16'(d + WIN + 1));
        chk("no_slip_on_unlock", 16'(slip_cnt), 16'd0);
        chk("state_after_unlock", 16'(state_out), 16'(ST_SEARCH));
        chk("err_after_unlock", err_count_out, 16'(ERR_ON));

        // Misaligned stream: slip at cycle WIN-1, hold, then relock.
        do_reset(2);
        repeat (WIN) tick(rot);
        chk("slip_count", 16'(slip_cnt), 16'd1);
        chk("slip_cycle", 16'(slip_cyc), 16'(WIN - 1));
        chk("state_slip_wait", 16'(state_out), 16'(ST_SLIP_WAIT));
        repeat (17) tick(tok[0]);
        chk("no_slip_in_hold", 16'(slip_cnt), 16'd1);
        chk("relock_cycle", 16'(rise_cyc), 16'(WIN + SLIP_HOLD + RUN + 1));
        chk("err_after_slip", err_count_out, 16'(ERR_ON));

        // Run completes on the window-expiry cycle: lock wins, no slip.
        do_reset(2);
        repeat (WIN - RUN - 1) tick(rand_data());
        repeat (16) tick(tok[2]);
        chk("tie_no_slip", 16'(slip_cnt), 16'd0);
        chk("tie_lock_cycle", 16'(rise_cyc), 16'(WIN));
        chk("tie_locked", 16'(locked_out), 16'd1);

        // Reset while in SLIP_WAIT.
        do_reset(2);
        repeat (WIN) tick(rot);
        chk("pre_rst_slip_wait", 16'(state_out), 16'(ST_SLIP_WAIT));
        do_reset(1);
        check_reset("rst_slip_wait");

        // Reset during the bitslip pulse, then post-reset latency.
        repeat (WIN - 1) tick(rot);
        chk("pre_rst_slip_pulse", 16'(bitslip_out), 16'd1);
        do_reset(1);
        check_reset("rst_slip_pulse");
        tick(10'b0100000000);
        tick(tok[3]);
        tick(rand_data());
        tick(tok[1]);
        repeat (3) tick(rand_data());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
